// File: rtl/elevator_pkg.sv
// Shared definitions for the single-car elevator controller.
// Holds the state encoding, the floor count and the floor index width.
package elevator_pkg;

    localparam int NUM_FLOORS = 5;
    localparam int FLOOR_W    = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;
    localparam logic [1:0] ST_DOOR = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        UP   = ST_UP,
        DOWN = ST_DOWN,
        DOOR = ST_DOOR
    } state_t;

endpackage

// File: rtl/elevator_req_latch.sv
// Edge-detecting request latch that turns the button vector into pending requests.
// A held-high button registers once; a fresh rising edge wins over a same-cycle clear.
module elevator_req_latch
    import elevator_pkg::*;
#(
    parameter int N = NUM_FLOORS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] buttons,
    input  logic [N-1:0] clear,
    output logic [N-1:0] pending
);

    logic [N-1:0] buttons_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            buttons_q <= '0;
        end else begin
            pending   <= (pending & ~clear) | (buttons & ~buttons_q);
            buttons_q <= buttons;
        end
    end

endmodule

// File: rtl/elevator_car.sv
// SCAN-policy controller for one elevator car: moves a floor at a time,
// keeps its direction while requests remain ahead, and dwells with doors open.
module elevator_car
    import elevator_pkg::*;
#(
    parameter int FLOOR_CYCLES = 4,
    parameter int DOOR_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] buttons,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open
);

    localparam int TMAX = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_CYCLES - 1);

    state_t                  state, state_n;
    logic [TW-1:0]           timer, timer_n;
    logic [FLOOR_W-1:0]      floor_n;
    logic                    dir_up, dir_n;
    logic [NUM_FLOORS-1:0]   pending, clear, here_mask;

    function automatic logic above_of(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i > int'(f) && p[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic below_of(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i < int'(f) && p[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] one;
        one = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
        return one << f;
    endfunction

    // Resting decision: serve here first, else prefer the current direction.
    function automatic state_t decide(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f,
                                      input logic dir);
        logic a, b;
        a = above_of(p, f);
        b = below_of(p, f);
        if (p[f])
            return DOOR;
        else if (a && (dir || !b))
            return UP;
        else if (b)
            return DOWN;
        else
            return IDLE;
    endfunction

    elevator_req_latch #(.N(NUM_FLOORS)) u_req (
        .clk     (clk),
        .reset   (reset),
        .buttons (buttons),
        .clear   (clear),
        .pending (pending)
    );

    assign here_mask = onehot(current_floor);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            current_floor <= '0;
            dir_up        <= 1'b1;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            current_floor <= floor_n;
            dir_up        <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        floor_n = current_floor;
        dir_n   = dir_up;
        clear   = '0;
        unique case (state)
            IDLE: state_n = decide(pending, current_floor, dir_up);
            UP, DOWN: begin
                if (timer == FLOOR_LAST) begin
                    timer_n = '0;
                    floor_n = (state == UP) ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);
                    if (pending[floor_n])
                        state_n = DOOR;
                    else if (state == UP ? above_of(pending, floor_n) : below_of(pending, floor_n))
                        state_n = state;
                    else if (state == UP ? below_of(pending, floor_n) : above_of(pending, floor_n))
                        state_n = (state == UP) ? DOWN : UP;
                    else
                        state_n = IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            DOOR: begin
                // Presses for this floor are swallowed while open; doors never extend.
                clear = here_mask;
                if (timer == DOOR_LAST) begin
                    timer_n = '0;
                    state_n = decide(pending & ~here_mask, current_floor, dir_up);
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
        endcase
        if (state_n == DOOR && state != DOOR)
            clear = onehot(floor_n);
        if (state_n == UP)
            dir_n = 1'b1;
        else if (state_n == DOWN)
            dir_n = 1'b0;
    end

    assign moving_up   = (state == UP);
    assign moving_down = (state == DOWN);
    assign door_open   = (state == DOOR);

endmodule

// File: tb/tb_elevator_car.sv
// Directed self-checking bench for elevator_car with hand-computed cycle timing.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_elevator_car;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] buttons;
    logic [2:0] current_floor;
    logic       moving_up, moving_down, door_open;

    int errors = 0;
    int checks = 0;

    elevator_car #(.FLOOR_CYCLES(4), .DOOR_CYCLES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .buttons       (buttons),
        .current_floor (current_floor),
        .moving_up     (moving_up),
        .moving_down   (moving_down),
        .door_open     (door_open)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input int fl, input int up, input int dn, input int dr);
        checkOutput({tag, ".floor"}, int'(current_floor), fl);
        checkOutput({tag, ".up"},    int'(moving_up),     up);
        checkOutput({tag, ".down"},  int'(moving_down),   dn);
        checkOutput({tag, ".door"},  int'(door_open),     dr);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle press; returns just after the edge that latches it.
    task automatic applyStimulus(input logic [4:0] b);
        buttons = b;
        step(1);
        buttons = 5'b00000;
    endtask

    initial begin
        reset   = 1'b1;
        buttons = 5'b00000;
        step(2);
        checkStatus("rst", 0, 0, 0, 0);
        reset = 1'b0;
        step(4);
        checkStatus("idle0", 0, 0, 0, 0);

        // Single request 0 -> 3
        applyStimulus(5'b01000);
        checkStatus("t2_k", 0, 0, 0, 0);
        step(1);
        checkStatus("t2_leave", 0, 1, 0, 0);
        step(4);
        checkStatus("t2_f1", 1, 1, 0, 0);
        step(8);
        checkStatus("t2_arr3", 3, 0, 0, 1);
        step(1);
        checkStatus("t2_door2", 3, 0, 0, 1);
        step(1);
        checkStatus("t2_idle", 3, 0, 0, 0);

        // From 3: floor 1, then floor 4 pressed during descent
        applyStimulus(5'b00010);
        step(1);
        checkStatus("t3_down", 3, 0, 1, 0);
        applyStimulus(5'b10000);
        checkStatus("t3_press4", 3, 0, 1, 0);
        step(3);
        checkStatus("t3_f2", 2, 0, 1, 0);
        step(4);
        checkStatus("t3_arr1", 1, 0, 0, 1);
        step(2);
        checkStatus("t3_rev", 1, 1, 0, 0);
        step(12);
        checkStatus("t3_arr4", 4, 0, 0, 1);
        step(2);
        checkStatus("t3_idle", 4, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            checkStatus("t3_stay4", 4, 0, 0, 0);
        end

        // SCAN: at floor 2 going up with 4 and 0 pending
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        checkStatus("t4_rst", 0, 0, 0, 0);
        applyStimulus(5'b10000);
        step(1);
        checkStatus("t4_up", 0, 1, 0, 0);
        step(8);
        checkStatus("t4_f2", 2, 1, 0, 0);
        applyStimulus(5'b00001);
        checkStatus("t4_press0", 2, 1, 0, 0);
        step(3);
        checkStatus("t4_f3", 3, 1, 0, 0);
        step(4);
        checkStatus("t4_arr4", 4, 0, 0, 1);
        step(2);
        checkStatus("t4_rev", 4, 0, 1, 0);
        step(16);
        checkStatus("t4_arr0", 0, 0, 0, 1);
        step(2);
        checkStatus("t4_idle", 0, 0, 0, 0);

        // Held-high button at the current floor is served once
        buttons = 5'b00001;
        step(1);
        checkStatus("t5_k", 0, 0, 0, 0);
        step(1);
        checkStatus("t5_door", 0, 0, 0, 1);
        step(2);
        checkStatus("t5_close", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            checkOutput("t5_hold.door", int'(door_open), 0);
        end
        buttons = 5'b00000;

        // Asynchronous reset between floors 1 and 2
        applyStimulus(5'b01000);
        step(1);
        checkStatus("t6_up", 0, 1, 0, 0);
        step(6);
        checkStatus("t6_mid", 1, 1, 0, 0);
        reset = 1'b1;
        #2;
        checkStatus("t6_async", 0, 0, 0, 0);
        step(2);
        reset = 1'b0;
        step(20);
        checkStatus("t6_after", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
